// File: rtl/mult_cost_div.sv
// rtl/mult_cost_div.sv - sequential signed restoring divider with valid/ready handshake
//
// Purpose: divides an a_size-bit signed dividend by a b_size-bit signed
// divisor, truncating toward zero (same results as Verilog / and %).
// One restoring step per cycle on the operand magnitudes; constant latency
// for every operand pair, including divide-by-zero and quotient overflow.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   a          signed dividend (a_size bits)
//   b          signed divisor (b_size bits)
//   in_valid   a/b valid
//   in_ready   block can accept a/b (high in IDLE)
//   q          signed quotient (a_size bits)
//   r          signed remainder (b_size bits), sign of dividend or zero
//   dz         divide-by-zero flag for the current result
//   ovf        quotient-overflow flag for the current result
//   out_valid  q/r/dz/ovf valid (high in DONE)
//   out_ready  consumer accepts result
module mult_cost_div #(
    parameter int a_size = 18,
    parameter int b_size = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [a_size-1:0] a,
    input  logic [b_size-1:0] b,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [a_size-1:0] q,
    output logic [b_size-1:0] r,
    output logic              dz,
    output logic              ovf,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int cnt_w = $clog2(a_size + 1);
    localparam logic [cnt_w-1:0]  cnt_init = cnt_w'(a_size);
    localparam logic [a_size-1:0] a_min    = {1'b1, {(a_size-1){1'b0}}};
    localparam logic [a_size-1:0] a_max    = {1'b0, {(a_size-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_n;

    logic [cnt_w-1:0]  cnt;
    // Magnitudes are held as unsigned values: an a_size-bit unsigned field
    // already covers |-2^(a_size-1)|, so no extra guard bit is needed.
    logic [a_size-1:0] quot;     // dividend bits shift out, quotient bits shift in
    logic [b_size-1:0] rem;      // partial remainder, always < divisor magnitude
    logic [b_size-1:0] b_mag;
    logic              q_neg;
    logic              a_neg;
    logic              dz_c;
    logic              ovf_c;

    logic              accept;
    logic [b_size:0]   shifted;
    logic              take;
    logic [b_size-1:0] rem_n;
    logic [a_size-1:0] q_signed;
    logic [b_size-1:0] r_signed;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // Restoring step: bring down the next dividend bit, subtract if it fits.
    // When it fits, the difference is below b_mag, so a b_size-bit subtract
    // is exact.
    always_comb begin
        shifted  = {rem, quot[a_size-1]};
        take     = (shifted >= {1'b0, b_mag});
        rem_n    = take ? (shifted[b_size-1:0] - b_mag) : shifted[b_size-1:0];
        q_signed = q_neg ? (a_size'(0) - quot) : quot;
        r_signed = a_neg ? (b_size'(0) - rem) : rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept)     state_n = CALC;
            CALC:    if (cnt == '0)  state_n = DONE;
            DONE:    if (out_ready)  state_n = IDLE;
            default:                 state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            quot  <= '0;
            rem   <= '0;
            b_mag <= '0;
            q_neg <= 1'b0;
            a_neg <= 1'b0;
            dz_c  <= 1'b0;
            ovf_c <= 1'b0;
            q     <= '0;
            r     <= '0;
            dz    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        quot  <= a[a_size-1] ? (a_size'(0) - a) : a;
                        b_mag <= b[b_size-1] ? (b_size'(0) - b) : b;
                        rem   <= '0;
                        cnt   <= cnt_init;
                        q_neg <= a[a_size-1] ^ b[b_size-1];
                        a_neg <= a[a_size-1];
                        dz_c  <= (b == '0);
                        ovf_c <= (a == a_min) && (b == '1);
                    end
                end
                CALC: begin
                    if (cnt != '0) begin
                        quot <= {quot[a_size-2:0], take};
                        rem  <= rem_n;
                        cnt  <= cnt - 1'b1;
                    end else if (dz_c) begin
                        // Saturate toward the sign of the dividend.
                        q   <= a_neg ? a_min : a_max;
                        r   <= '0;
                        dz  <= 1'b1;
                        ovf <= 1'b0;
                    end else if (ovf_c) begin
                        q   <= a_max;
                        r   <= '0;
                        dz  <= 1'b0;
                        ovf <= 1'b1;
                    end else begin
                        q   <= q_signed;
                        r   <= r_signed;
                        dz  <= 1'b0;
                        ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
